svc_axil_uart_initiator: RTL

SVC_AXIL_UART_INITIATOR -- requirements
Module: svc_axil_uart_initiator

---
 rtl/svc_uart_bridge_pkg.sv | 25 ++
 rtl/svc_axil_uart_initiator.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/svc_uart_bridge_pkg.sv
// Wire-protocol constants shared by the AXI-Lite-to-UART initiator and the
// UART-to-AXI-Lite bridge at the remote end, plus the initiator state type.
package svc_uart_bridge_pkg;

    localparam logic [15:0] CMD_MAGIC    = 16'hF0B0;
    localparam logic [7:0]  OP_READ      = 8'h00;
    localparam logic [7:0]  OP_WRITE     = 8'h01;
    localparam logic [7:0]  RESP_MAGIC   = 8'hAB;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [1:0]  RESP_SLVERR  = 2'b10;

    // Index of the final command byte: magic(2) + op(1) + addr(4) [+ data(4)]
    localparam logic [3:0]  CMD_LAST_RD  = 4'd6;
    localparam logic [3:0]  CMD_LAST_WR  = 4'd10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TX_CMD   = 3'd1,
        RX_MAGIC = 3'd2,
        RX_RESP  = 3'd3,
        RX_DATA  = 3'd4,
        AXI_RESP = 3'd5
    } init_state_e;

endpackage

// File: rtl/svc_axil_uart_initiator.sv
// AXI-Lite subordinate that tunnels each transaction, one at a time, over a
// byte stream to a remote UART/AXI-Lite bridge and returns its response.
module svc_axil_uart_initiator
    import svc_uart_bridge_pkg::*;
#(
    parameter int AXIL_ADDR_WIDTH = 32,
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES  = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                       s_axil_awvalid,
    output logic                       s_axil_awready,
    input  logic [AXIL_DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [AXIL_STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                       s_axil_wvalid,
    output logic                       s_axil_wready,
    output logic [1:0]                 s_axil_bresp,
    output logic                       s_axil_bvalid,
    input  logic                       s_axil_bready,
    input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic                       s_axil_arvalid,
    output logic                       s_axil_arready,
    output logic [AXIL_DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]                 s_axil_rresp,
    output logic                       s_axil_rvalid,
    input  logic                       s_axil_rready,
    output logic                       utx_valid,
    output logic [7:0]                 utx_data,
    input  logic                       utx_ready,
    input  logic                       urx_valid,
    input  logic [7:0]                 urx_data,
    output logic                       urx_ready
);

    localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    init_state_e r_state, w_state_nxt;
    logic        r_is_write;
    logic [79:0] r_shift;
    logic [3:0]  r_cnt, r_last;
    logic        r_utx_valid;
    logic [7:0]  r_utx_data;
    logic [1:0]  r_byte_idx;
    logic        r_bvalid, r_rvalid;
    logic [1:0]  r_bresp, r_rresp;
    logic [31:0] r_rdata;
    logic [31:0] r_timer;

    logic w_wr_req, w_strb_ok, w_idle, w_rx_state, w_urx_ready;
    logic w_utx_hs, w_urx_hs, w_b_hs, w_r_hs, w_timeout;
    logic [31:0] w_awaddr, w_araddr, w_wdata;

    assign w_awaddr    = 32'(s_axil_awaddr);
    assign w_araddr    = 32'(s_axil_araddr);
    assign w_wdata     = 32'(s_axil_wdata);
    assign w_wr_req    = s_axil_awvalid && s_axil_wvalid;
    assign w_strb_ok   = &s_axil_wstrb;
    assign w_idle      = rst_n && (r_state == IDLE);
    assign w_rx_state  = r_state inside {RX_MAGIC, RX_RESP, RX_DATA};
    assign w_urx_ready = !rst_n || (r_state inside {IDLE, RX_MAGIC, RX_RESP, RX_DATA});
    assign w_utx_hs    = r_utx_valid && utx_ready;
    assign w_urx_hs    = urx_valid && w_urx_ready;
    assign w_b_hs      = r_bvalid && s_axil_bready;
    assign w_r_hs      = r_rvalid && s_axil_rready;
    assign w_timeout   = (TIMEOUT_CYCLES > 0) && w_rx_state && (r_timer == TO_LAST);

    assign s_axil_awready = w_idle && w_wr_req;
    assign s_axil_wready  = w_idle && w_wr_req;
    assign s_axil_arready = w_idle && s_axil_arvalid && !w_wr_req;
    assign s_axil_bvalid  = r_bvalid;
    assign s_axil_bresp   = r_bresp;
    assign s_axil_rvalid  = r_rvalid;
    assign s_axil_rresp   = r_rresp;
    assign s_axil_rdata   = AXIL_DATA_WIDTH'(r_rdata);
    assign utx_valid      = r_utx_valid;
    assign utx_data       = r_utx_data;
    assign urx_ready      = w_urx_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; a received byte takes priority over a same-cycle timeout
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_wr_req)            w_state_nxt = w_strb_ok ? TX_CMD : AXI_RESP;
                else if (s_axil_arvalid) w_state_nxt = TX_CMD;
                else                     w_state_nxt = IDLE;
            end
            TX_CMD: begin
                if (w_utx_hs && (r_cnt == r_last)) w_state_nxt = RX_MAGIC;
                else                               w_state_nxt = TX_CMD;
            end
            RX_MAGIC: begin
                if (w_urx_hs)       w_state_nxt = (urx_data == RESP_MAGIC) ? RX_RESP : RX_MAGIC;
                else if (w_timeout) w_state_nxt = AXI_RESP;
                else                w_state_nxt = RX_MAGIC;
            end
            RX_RESP: begin
                if (w_urx_hs)       w_state_nxt = r_is_write ? AXI_RESP : RX_DATA;
                else if (w_timeout) w_state_nxt = AXI_RESP;
                else                w_state_nxt = RX_RESP;
            end
            RX_DATA: begin
                if (w_urx_hs)       w_state_nxt = (r_byte_idx == 2'd3) ? AXI_RESP : RX_DATA;
                else if (w_timeout) w_state_nxt = AXI_RESP;
                else                w_state_nxt = RX_DATA;
            end
            AXI_RESP: begin
                if (w_b_hs || w_r_hs) w_state_nxt = IDLE;
                else                  w_state_nxt = AXI_RESP;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Command shifter, response capture, AXI response registers and timeout counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_is_write  <= 1'b0;
            r_shift     <= 80'h0;
            r_cnt       <= 4'd0;
            r_last      <= 4'd0;
            r_utx_valid <= 1'b0;
            r_utx_data  <= 8'h00;
            r_byte_idx  <= 2'd0;
            r_bvalid    <= 1'b0;
            r_rvalid    <= 1'b0;
            r_bresp     <= 2'b00;
            r_rresp     <= 2'b00;
            r_rdata     <= 32'h0;
            r_timer     <= 32'h0;
        end else begin
            if (((r_state == TX_CMD) && (w_state_nxt == RX_MAGIC)) || w_urx_hs) begin
                r_timer <= 32'h0;
            end else if (w_rx_state) begin
                r_timer <= r_timer + 32'd1;
            end else begin
                r_timer <= r_timer;
            end

            if (w_rx_state && !w_urx_hs && w_timeout) begin
                if (r_is_write) begin
                    r_bvalid <= 1'b1;
                    r_bresp  <= RESP_SLVERR;
                end else begin
                    r_rvalid <= 1'b1;
                    r_rresp  <= RESP_SLVERR;
                    r_rdata  <= 32'h0;
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_wr_req) begin
                        r_is_write <= 1'b1;
                        if (w_strb_ok) begin
                            r_utx_valid <= 1'b1;
                            r_utx_data  <= CMD_MAGIC[7:0];
                            r_shift     <= {w_wdata, w_awaddr, OP_WRITE, CMD_MAGIC[15:8]};
                            r_cnt       <= 4'd0;
                            r_last      <= CMD_LAST_WR;
                        end else begin
                            r_bvalid <= 1'b1;
                            r_bresp  <= RESP_SLVERR;
                        end
                    end else if (s_axil_arvalid) begin
                        r_is_write  <= 1'b0;
                        r_utx_valid <= 1'b1;
                        r_utx_data  <= CMD_MAGIC[7:0];
                        r_shift     <= {32'h0, w_araddr, OP_READ, CMD_MAGIC[15:8]};
                        r_cnt       <= 4'd0;
                        r_last      <= CMD_LAST_RD;
                    end
                end
                TX_CMD: begin
                    if (w_utx_hs) begin
                        if (r_cnt == r_last) begin
                            r_utx_valid <= 1'b0;
                        end else begin
                            r_utx_data <= r_shift[7:0];
                            r_shift    <= {8'h00, r_shift[79:8]};
                            r_cnt      <= r_cnt + 4'd1;
                        end
                    end
                end
                RX_RESP: begin
                    if (w_urx_hs) begin
                        r_byte_idx <= 2'd0;
                        if (r_is_write) begin
                            r_bvalid <= 1'b1;
                            r_bresp  <= urx_data[1:0];
                        end else begin
                            r_rresp <= urx_data[1:0];
                        end
                    end
                end
                RX_DATA: begin
                    if (w_urx_hs) begin
                        r_rdata[{r_byte_idx, 3'b000} +: 8] <= urx_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) r_rvalid <= 1'b1;
                    end
                end
                AXI_RESP: begin
                    if (w_b_hs) r_bvalid <= 1'b0;
                    if (w_r_hs) r_rvalid <= 1'b0;
                end
                default: begin
                    r_utx_valid <= r_utx_valid;
                end
            endcase
        end
    end

endmodule
